// File: rtl/pdm_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_seq_pkg
//  Brief    : Shared types and constants for the PDM breathing sequencer:
//             FSM state encoding, waveform mode codes and full-scale level.
//  Revision : 1.0  initial release
// ============================================================================
package pdm_seq_pkg;

    // Sequencer states; the numeric values are visible on the phase output
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RISE   = 3'd1,
        ST_PEAK   = 3'd2,
        ST_FALL   = 3'd3,
        ST_TROUGH = 3'd4,
        ST_MANUAL = 3'd5
    } seq_state_t;

    // Waveform selection codes on the mode input
    localparam logic [1:0] MODE_TRI = 2'd0;
    localparam logic [1:0] MODE_SAW = 2'd1;
    localparam logic [1:0] MODE_SQR = 2'd2;
    localparam logic [1:0] MODE_MAN = 2'd3;

    // Full-scale sample value for a DATA_W-bit modulator input
    function automatic int unsigned calc_level_max(input int unsigned data_w);
        return (32'd1 << data_w) - 32'd1;
    endfunction

endpackage : pdm_seq_pkg
`default_nettype wire

// File: rtl/pdm_seq_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_seq_prescaler
//  Brief    : Tick generator for the sequencer. Counts while run is high and
//             emits a one-cycle tick every (speed+1) << PRESC_SHIFT cycles.
//             The terminal value follows speed live, so a speed change is
//             seen at the next wrap; a count already above the new terminal
//             runs on to the counter width boundary before wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module pdm_seq_prescaler
    import pdm_seq_pkg::*;
#(
    parameter int PRESC_SHIFT = 4,
    parameter int PRESC_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       run,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [2:0]         w_mult;
    logic [PRESC_W-1:0] w_terminal;
    logic [PRESC_W-1:0] r_count;

    // Terminal count = ((speed+1) << PRESC_SHIFT) - 1
    assign w_mult     = {1'b0, speed} + 3'd1;
    assign w_terminal = (PRESC_W'(w_mult) << PRESC_SHIFT) - PRESC_W'(1);
    assign tick       = run && (r_count == w_terminal);

    // Prescaler counter: clear wins, wraps to zero on the tick cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            if (tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + PRESC_W'(1);
            end
        end
    end

endmodule : pdm_seq_prescaler
`default_nettype wire

// File: rtl/pdm_breath_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_breath_seq
//  Brief    : Brightness waveform sequencer feeding a PDM modulator.
//             Produces triangle, sawtooth and square profiles from a
//             prescaled tick, or forwards a manual level. Every change of
//             the registered level is flagged by a one-cycle write_en.
//  Revision : 1.0  initial release
// ============================================================================
module pdm_breath_seq
    import pdm_seq_pkg::*;
#(
    parameter int DATA_W      = 5,
    parameter int PRESC_SHIFT = 4,
    parameter int PRESC_W     = 8,
    parameter int DWELL       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    input  logic [DATA_W-1:0] manual_level,
    output logic [DATA_W-1:0] level,
    output logic              write_en,
    output logic [2:0]        phase
);

    localparam logic [DATA_W-1:0] c_level_max     = DATA_W'(calc_level_max(DATA_W));
    localparam logic [DATA_W-1:0] c_level_pre_max = c_level_max - DATA_W'(1);
    localparam int                c_dwell_w       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(DWELL - 1);

    seq_state_t           r_state;
    seq_state_t           w_state_next;
    logic [DATA_W-1:0]    r_level;
    logic [DATA_W-1:0]    w_level_next;
    logic [c_dwell_w-1:0] r_dwell;
    logic [c_dwell_w-1:0] w_dwell_next;
    logic                 r_write_en;
    logic [1:0]           r_prev_mode;
    logic                 w_abort;
    logic                 w_run;
    logic                 w_clear;
    logic                 w_tick;

    // The prescaler only runs in the waveform states; IDLE holds it at zero
    // so every waveform starts with a full tick period.
    assign w_run   = (r_state == ST_RISE) || (r_state == ST_PEAK) ||
                     (r_state == ST_FALL) || (r_state == ST_TROUGH);
    assign w_clear = (r_state == ST_IDLE);

    pdm_seq_prescaler #(
        .PRESC_SHIFT (PRESC_SHIFT),
        .PRESC_W     (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .run   (w_run),
        .speed (speed),
        .tick  (w_tick)
    );

    // Disable or a mode switch aborts whatever is running
    assign w_abort = !enable || (mode != r_prev_mode);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, next level and next dwell count
    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        w_dwell_next = r_dwell;

        if (w_abort) begin
            w_state_next = ST_IDLE;
            w_level_next = '0;
            w_dwell_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_dwell_next = '0;
                    case (mode)
                        MODE_TRI, MODE_SAW: w_state_next = ST_RISE;
                        MODE_SQR:           w_state_next = ST_TROUGH;
                        default:            w_state_next = ST_MANUAL;
                    endcase
                end

                ST_RISE: begin
                    if (w_tick) begin
                        if (r_level == c_level_max) begin
                            // Sawtooth wraps; a triangle can only be here
                            // at full scale if it has not yet moved to PEAK.
                            if (mode == MODE_SAW) begin
                                w_level_next = '0;
                            end else begin
                                w_state_next = ST_PEAK;
                                w_dwell_next = '0;
                            end
                        end else begin
                            w_level_next = r_level + DATA_W'(1);
                            if ((mode != MODE_SAW) && (r_level == c_level_pre_max)) begin
                                w_state_next = ST_PEAK;
                                w_dwell_next = '0;
                            end
                        end
                    end
                end

                ST_PEAK: begin
                    if (w_tick) begin
                        if (r_dwell == c_dwell_last) begin
                            w_dwell_next = '0;
                            if (mode == MODE_SQR) begin
                                w_state_next = ST_TROUGH;
                                w_level_next = '0;
                            end else begin
                                w_state_next = ST_FALL;
                            end
                        end else begin
                            w_dwell_next = r_dwell + c_dwell_w'(1);
                        end
                    end
                end

                ST_FALL: begin
                    // Saturating descent: the step that reaches zero exits
                    if (w_tick) begin
                        if (r_level <= DATA_W'(1)) begin
                            w_level_next = '0;
                            w_state_next = ST_TROUGH;
                            w_dwell_next = '0;
                        end else begin
                            w_level_next = r_level - DATA_W'(1);
                        end
                    end
                end

                ST_TROUGH: begin
                    if (w_tick) begin
                        if (r_dwell == c_dwell_last) begin
                            w_dwell_next = '0;
                            if (mode == MODE_SQR) begin
                                w_state_next = ST_PEAK;
                                w_level_next = c_level_max;
                            end else begin
                                w_state_next = ST_RISE;
                            end
                        end else begin
                            w_dwell_next = r_dwell + c_dwell_w'(1);
                        end
                    end
                end

                ST_MANUAL: begin
                    w_level_next = manual_level;
                end

                default: begin
                    w_state_next = ST_IDLE;
                    w_level_next = '0;
                    w_dwell_next = '0;
                end
            endcase
        end
    end

    // Level, strobe, dwell and previous-mode registers. The strobe is raised
    // only when the stored level actually changes value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level     <= '0;
            r_write_en  <= 1'b0;
            r_dwell     <= '0;
            r_prev_mode <= MODE_TRI;
        end else begin
            r_level     <= w_level_next;
            r_write_en  <= (w_level_next != r_level);
            r_dwell     <= w_dwell_next;
            r_prev_mode <= mode;
        end
    end

    assign level    = r_level;
    assign write_en = r_write_en;
    assign phase    = r_state;

endmodule : pdm_breath_seq
`default_nettype wire

// File: tb/tb_pdm_breath_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pdm_breath_seq
//  Brief    : Self-checking bench for pdm_breath_seq. The reference model
//             derives level and phase from the tick count since a waveform
//             started, using closed-form period arithmetic per mode.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pdm_breath_seq;

    localparam int DATA_W      = 5;
    localparam int PRESC_SHIFT = 4;
    localparam int PRESC_W     = 8;
    localparam int DWELL       = 4;
    localparam int LMAX        = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [1:0]        speed = 2'd0;
    logic [DATA_W-1:0] manual_level = '0;
    logic [DATA_W-1:0] level;
    logic              write_en;
    logic [2:0]        phase;

    pdm_breath_seq #(
        .DATA_W      (DATA_W),
        .PRESC_SHIFT (PRESC_SHIFT),
        .PRESC_W     (PRESC_W),
        .DWELL       (DWELL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mode         (mode),
        .speed        (speed),
        .manual_level (manual_level),
        .level        (level),
        .write_en     (write_en),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    int exp_level  = 0;
    int exp_we     = 0;
    int exp_phase  = 0;
    bit seg_active = 1'b0;
    int seg_mode   = 0;
    int seg_speed  = 0;
    int seg_n      = 0;
    int last_mode  = 0;
    bit manual_rand = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Level/phase after k ticks of a waveform, from its period shape
    task automatic wave_at(input int md, input int k, output int lv, output int ph);
        int per;
        int pos;
        lv = 0;
        ph = 0;
        if (md == 0) begin
            per = 2 * LMAX + 2 * DWELL;
            pos = k % per;
            if (pos < LMAX) begin
                lv = pos;  ph = 1;
            end else if (pos < LMAX + DWELL) begin
                lv = LMAX; ph = 2;
            end else if (pos < 2 * LMAX + DWELL) begin
                lv = 2 * LMAX + DWELL - pos; ph = 3;
            end else begin
                lv = 0;    ph = 4;
            end
        end else if (md == 1) begin
            lv = k % (LMAX + 1);
            ph = 1;
        end else begin
            pos = k % (2 * DWELL);
            if (pos < DWELL) begin
                lv = 0;    ph = 4;
            end else begin
                lv = LMAX; ph = 2;
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs held at that edge
    task automatic model_edge();
        int old;
        int lv;
        int ph;
        old = exp_level;
        if (!enable || (int'(mode) != last_mode)) begin
            exp_level  = 0;
            exp_phase  = 0;
            seg_active = 1'b0;
        end else if (!seg_active) begin
            seg_active = 1'b1;
            seg_mode   = int'(mode);
            seg_speed  = int'(speed);
            seg_n      = 0;
            exp_phase  = (seg_mode == 3) ? 5 : (seg_mode == 2) ? 4 : 1;
        end else begin
            seg_n++;
            if (seg_mode == 3) begin
                exp_level = int'(manual_level);
            end else begin
                wave_at(seg_mode, seg_n / ((seg_speed + 1) << PRESC_SHIFT), lv, ph);
                exp_level = lv;
                exp_phase = ph;
            end
        end
        exp_we    = (exp_level != old) ? 1 : 0;
        last_mode = int'(mode);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("level", int'(level), exp_level);
        check_val("write_en", int'(write_en), exp_we);
        check_val("phase", int'(phase), exp_phase);
    endtask

    // Park in IDLE with the new settings, then sample enable (edge E0)
    task automatic start_seg(input int md, input int sp);
        enable = 1'b0;
        mode   = 2'(md);
        speed  = 2'(sp);
        step();
        enable = 1'b1;
        step();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (manual_rand && (seg_mode == 3) && ($urandom_range(0, 1) == 1))
                manual_level = DATA_W'($urandom_range(0, LMAX));
            step();
        end
    endtask

    // Reset between edges, check outputs clear without a clock, then release
    task automatic async_reset_mid();
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_async_level", int'(level), 0);
        check_val("rst_async_we", int'(write_en), 0);
        check_val("rst_async_phase", int'(phase), 0);
        exp_level  = 0;
        exp_we     = 0;
        exp_phase  = 0;
        seg_active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_hold_level", int'(level), 0);
        check_val("rst_hold_phase", int'(phase), 0);
        enable = 1'b0;
        reset  = 1'b0;
        step();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int md;
        int sp;
        int len;

        repeat (3) @(negedge clk);
        check_val("reset_level", int'(level), 0);
        check_val("reset_we", int'(write_en), 0);
        check_val("reset_phase", int'(phase), 0);
        reset = 1'b0;
        step();
        step();

        // Triangle start-up and one full period at speed 0
        start_seg(0, 0);
        cycles(16);
        check_val("tri_first_level", int'(level), 1);
        check_val("tri_first_we", int'(write_en), 1);
        cycles(480);
        check_val("tri_peak_level", int'(level), LMAX);
        check_val("tri_peak_phase", int'(phase), 2);
        cycles(560);
        check_val("tri_trough_level", int'(level), 0);
        check_val("tri_trough_phase", int'(phase), 4);
        cycles(80);
        check_val("tri_repeat_level", int'(level), 1);

        // Sawtooth wrap at speed 3
        start_seg(1, 3);
        cycles(64 * 31);
        check_val("saw_top_level", int'(level), LMAX);
        cycles(64);
        check_val("saw_wrap_level", int'(level), 0);
        check_val("saw_wrap_we", int'(write_en), 1);
        check_val("saw_wrap_phase", int'(phase), 1);

        // Square
        start_seg(2, 0);
        check_val("sqr_start_phase", int'(phase), 4);
        cycles(64);
        check_val("sqr_high_level", int'(level), LMAX);
        check_val("sqr_high_phase", int'(phase), 2);
        cycles(64);
        check_val("sqr_low_level", int'(level), 0);
        check_val("sqr_low_we", int'(write_en), 1);

        // Manual forwarding 0 -> 17 -> 17 -> 5
        manual_level = '0;
        start_seg(3, 0);
        manual_level = 5'd17;
        step();
        check_val("man_17_level", int'(level), 17);
        check_val("man_17_we", int'(write_en), 1);
        step();
        check_val("man_17_repeat_we", int'(write_en), 0);
        manual_level = 5'd5;
        step();
        check_val("man_5_level", int'(level), 5);

        // Abort mid-rise at level 12 by dropping enable
        start_seg(0, 0);
        cycles(192);
        check_val("abort_en_pre", int'(level), 12);
        enable = 1'b0;
        step();
        check_val("abort_en_level", int'(level), 0);
        check_val("abort_en_we", int'(write_en), 1);
        step();
        check_val("abort_en_single", int'(write_en), 0);

        // Abort mid-rise at level 12 by switching to square
        start_seg(0, 0);
        cycles(192);
        mode = 2'd2;
        step();
        check_val("abort_md_level", int'(level), 0);
        check_val("abort_md_phase", int'(phase), 0);
        step();
        check_val("abort_md_next_phase", int'(phase), 4);

        // Asynchronous reset while falling
        start_seg(0, 0);
        cycles(16 * 40);
        check_val("fall_phase", int'(phase), 3);
        async_reset_mid();

        // Randomized segments
        manual_rand = 1'b1;
        for (int s = 0; s < 30; s++) begin
            md  = int'($urandom_range(0, 3));
            sp  = int'($urandom_range(0, 3));
            len = int'($urandom_range(10, 1200));
            start_seg(md, sp);
            cycles(len);
            case ($urandom_range(0, 5))
                0: async_reset_mid();
                1, 2: begin
                    enable = 1'b0;
                    step();
                end
                default: begin
                    mode = 2'((md + int'($urandom_range(1, 3))) % 4);
                    step();
                    step();
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_pdm_breath_seq
`default_nettype wire

// File: doc/pdm_breath_seq.md
# pdm_breath_seq

Waveform sequencer that sits directly upstream of the 5-bit PDM modulator and drives its sample input and write strobe. It generates triangle ("breathing"), sawtooth and square brightness profiles, or forwards a manual level. Each new level is presented with a one-cycle `write_en` pulse. The modulator captures `level` on the clock edge that follows that pulse.

## Interface
- `DATA_W`, 5: width of `level`; `LEVEL_MAX` = 2^DATA_W-1 (31).
- `PRESC_SHIFT`, 4: base prescaler shift; tick period = (speed+1) << PRESC_SHIFT cycles.
- `PRESC_W`, 8: prescaler counter width; must hold 4<<PRESC_SHIFT.
- `DWELL`, 4: ticks spent in PEAK/TROUGH before leaving; must be ≥1.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  run sequencer; low forces IDLE.
- `mode`  in  2  0 triangle, 1 sawtooth, 2 square, 3 manual.
- `speed`  in  2  prescaler multiplier select (speed+1).
- `manual_level`  in  DATA_W  level forwarded in manual mode.
- `level`  out  DATA_W  registered sample to the modulator's `pdm_input`.
- `write_en`  out  1  registered one-cycle strobe, high in the cycle `level` holds a new value.
- `phase`  out  3  current state encoding.

## Operation
- **States and encodings:** IDLE=0, RISE=1, PEAK=2, FALL=3, TROUGH=4, MANUAL=5.
- **Reset values:** `level`=0, `write_en`=0, `phase`=IDLE, prescaler=0, dwell counter=0.
- **Prescaler:** clears on any state change out of IDLE. It counts while in RISE, PEAK, FALL or TROUGH. A tick occurs in the cycle where count == ((speed+1)<<PRESC_SHIFT)-1, and the count wraps to 0 on that cycle.
- **IDLE with enable=1:**
  - mode 0 or 1 → RISE.
  - mode 2 → TROUGH.
  - mode 3 → MANUAL.
- **RISE:**
  - On each tick, `level` increments by 1.
  - Triangle: on the tick that writes LEVEL_MAX, go to PEAK.
  - Sawtooth: on a tick with `level`==LEVEL_MAX, `level` wraps to 0; state stays RISE.
- **PEAK:**
  - The dwell counter is cleared on entry and increments on each tick.
  - On the tick where dwell==DWELL-1:
    - triangle → FALL, `level` unchanged;
    - square → TROUGH, `level`←0.
- **FALL:** on each tick, `level` decrements by 1; the tick that writes 0 goes to TROUGH. FALL saturates at 0; it never wraps.
- **TROUGH:** same dwell rule as PEAK. On exit:
  - triangle → RISE, `level` unchanged;
  - square → PEAK, `level`←LEVEL_MAX.
- **MANUAL:** every cycle where `manual_level` != `level`, `level`←`manual_level`. No prescaler involvement.
- **write_en:**
  - Asserted exactly in the cycle after every edge that changes `level`.
  - Never asserted when `level` is rewritten with the same value.
  - Never asserted for two consecutive cycles, except in MANUAL mode when `manual_level` changes every cycle.
- **Priority, highest first:**
  1. reset;
  2. enable=0: next edge → IDLE, `level`←0, strobe only if `level` was nonzero;
  3. mode change (mode != registered previous mode): next edge → IDLE, `level`←0, strobe only if `level` was nonzero, then normal IDLE exit;
  4. normal transitions.

## Timing
- **Level updates:** `level` and `write_en` are registered together. The downstream stage samples both on the edge after the strobe, so latency from tick to modulator capture is 1 cycle.
- **First strobe after enable:** enable is first sampled at edge E0 (IDLE→RISE). Edges E1..E15 advance the prescaler. At E16 (speed 0, PRESC_SHIFT 4), `level`=1 and `write_en`=1.
- **Triangle period:** (2·LEVEL_MAX + 2·DWELL) ticks. With defaults at speed 0: 70·16 = 1120 cycles.
- **Square period:** 2·DWELL ticks. LEVEL_MAX is held DWELL ticks.
- **Manual latency:** `level` follows `manual_level` with 1-cycle latency.
- **Reset:** asserting reset mid-run clears all outputs immediately, without a clock. The first action after release requires enable to be sampled.
- **Speed changes:** take effect at the next prescaler wrap. The current count is not truncated unless count > new terminal, in which case the prescaler wraps at its width boundary.

## Structure
- **Package `pdm_seq_pkg`:**
  - state enum with the encodings above;
  - mode constants (MODE_TRI=0, MODE_SAW=1, MODE_SQR=2, MODE_MAN=3);
  - LEVEL_MAX derivation.
- **Sub-module `pdm_seq_prescaler`:**
  - counter with `clear`, `run` and `speed` inputs;
  - `tick` output;
  - parameters PRESC_SHIFT and PRESC_W.
- **Top level:** FSM, dwell counter, level register, strobe register, previous-mode register.

## Test plan
- **Triangle start-up:** reset, then enable=1, mode=0, speed=0 → first `write_en` at E16 with `level`=1. Subsequent strobes every 16 cycles. `level`=31 at tick 31, then held 4 more ticks. 30 on tick 36, 0 on tick 66; the period repeats at tick 70.
- **Sawtooth wrap:** mode=1, speed=3 → strobes every 64 cycles. After `level`=31, the next tick gives `level`=0 and `write_en`=1. `phase` stays 1.
- **Square:** mode=2 → `phase`=4 with `level`=0 for 4 ticks. Then `level`=31 with a strobe and `phase`=2. Four ticks later, `level`=0 with a strobe.
- **Manual forwarding:** mode=3, `manual_level` 0→17→17→5 on successive cycles → strobes only for 17 and 5, each 1 cycle after the input change. No strobe for the repeated 17.
- **Abort mid-rise at `level`=12:**
  - Drop enable → next edge `level`=0 with a single strobe and `phase`=0.
  - Repeat with a mode change 0→2 instead → same response, then `phase`=4.
- **Asynchronous reset:** assert reset mid-FALL between edges → `level`, `write_en` and `phase` go to 0 before the next edge. They stay 0 until enable is sampled after release.
